// File: rtl/fpnew_opgroup_result_arbiter.sv
// Round-robin merge of per-format slice results onto one registered output port.
// Carries the status-flag type used by the slices; only the result arbiter relies on it here.
package fpnew_pkg;
   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;
endpackage

module fpnew_opgroup_result_arbiter #(
   parameter int unsigned NumSlices = 4,
   parameter int unsigned Width     = 64,
   parameter type         TagType   = logic,
   localparam int unsigned IdxWidth = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumSlices-1:0][Width-1:0]      slice_result_i,
   input  fpnew_pkg::status_t [NumSlices-1:0]   slice_status_i,
   input  logic [NumSlices-1:0]                 slice_ext_bit_i,
   input  TagType [NumSlices-1:0]               slice_tag_i,
   input  logic [NumSlices-1:0]                 slice_valid_i,
   output logic [NumSlices-1:0]                 slice_ready_o,
   input  logic                                 flush_i,
   output logic [Width-1:0]                     result_o,
   output fpnew_pkg::status_t                   status_o,
   output logic                                 extension_bit_o,
   output TagType                               tag_o,
   output logic [IdxWidth-1:0]                  src_idx_o,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic                                 busy_o
);

   logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxWidth-1:0] gnt;
   logic [IdxWidth-1:0] cand_idx;
   int unsigned         cand;
   logic                found;
   logic                load;

   logic [Width-1:0]    result_q;
   fpnew_pkg::status_t  status_q;
   logic                ext_q;
   TagType              tag_q;
   logic [IdxWidth-1:0] src_idx_q;
   logic                out_valid_q;

   // Scan upward from the pointer with wrap; the first valid slice wins.
   always_comb begin
      gnt      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NumSlices; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= NumSlices) cand = cand - NumSlices;
         cand_idx = IdxWidth'(cand);
         if (!found && slice_valid_i[cand_idx]) begin
            found = 1'b1;
            gnt   = cand_idx;
         end
      end
   end

   assign load     = (|slice_valid_i) & ~flush_i & (~out_valid_q | out_ready_i);
   assign rr_ptr_d = (gnt == IdxWidth'(NumSlices - 1)) ? '0 : gnt + 1'b1;

   always_comb begin
      slice_ready_o = '0;
      if (load) slice_ready_o[gnt] = 1'b1;
   end

   // Data fields only change on a load, so a stalled or drained output stays put.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_q    <= '0;
         status_q    <= '0;
         ext_q       <= 1'b0;
         tag_q       <= '0;
         src_idx_q   <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else if (load) begin
         result_q    <= slice_result_i[gnt];
         status_q    <= slice_status_i[gnt];
         ext_q       <= slice_ext_bit_i[gnt];
         tag_q       <= slice_tag_i[gnt];
         src_idx_q   <= gnt;
         out_valid_q <= 1'b1;
         rr_ptr_q    <= rr_ptr_d;
      end else if (flush_i || out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign result_o        = result_q;
   assign status_o        = status_q;
   assign extension_bit_o = ext_q;
   assign tag_o           = tag_q;
   assign src_idx_o       = src_idx_q;
   assign out_valid_o     = out_valid_q;
   assign busy_o          = out_valid_q | (|slice_valid_i);

endmodule
